tdc_frame_sequencer: RTL and testbench
======================================

# tdc_frame_sequencer

Frames each TDC delayline capture and feeds it byte by byte to the UART transmitter. The block takes the sampled `DATASIZE`-bit thermometer word on a sample strobe and wraps it as sync byte, sequence byte, data bytes (LSB first), then XOR checksum. It paces the bytes with the UART push/done handshake. One capture can wait in a pending buffer, and further captures are dropped and counted. The block sits between the sampling register and `uart_tx`, and replaces ad-hoc fixed-length send loops.

## Interface
- `DATASIZE`, 64: capture width in bits; must be a multiple of 8, range 8..256. NBYTES = DATASIZE/8.
- `SYNC_BYTE`, 8'hA5: first byte of every frame.

- `clk10m`  in  1  system clock, 10 MHz.
- `rst`  in  1  reset; asynchronous, active-high.
- `sample_tick`  in  1  one-cycle strobe; `sample_data` is valid in this cycle.
- `sample_data`  in  DATASIZE  captured delayline word.
- `tx_push`  out  1  one-cycle request to the UART to send `tx_byte`.
- `tx_byte`  out  8  byte to send; held stable from `tx_push` until the matching `tx_done`.
- `tx_done`  in  1  one-cycle pulse from the UART when the byte has finished.
- `busy`  out  1  a frame is in progress.
- `frame_cnt`  out  8  count of completed frames; wraps.
- `overrun_cnt`  out  8  count of dropped captures; saturates at 255.

## Operation
- Frame is NBYTES+3 bytes: SYNC_BYTE, SEQ, D0..D(NBYTES-1), CHK.
  - SEQ = `frame_cnt` at frame start.
  - D0 = active[7:0].
  - CHK = SEQ ^ D0 ^ … ^ D(NBYTES-1).
- Storage:
  - Active register: DATASIZE bits plus latched SEQ.
  - Pending register: DATASIZE bits plus valid flag.
  - Byte index: width clog2(NBYTES+3).
  - Running CHK accumulator: 8 bits.
- States:
  - IDLE: `busy`=0. A `sample_tick` latches data into active and goes to SEND.
  - SEND: one cycle. Assert `tx_push`, drive `tx_byte` for the current index, XOR that byte into CHK (except SYNC and the CHK byte itself), go to WAIT.
  - WAIT: hold `tx_byte`.
    - On `tx_done` with index < NBYTES+2: index+1, go to SEND.
    - On `tx_done` with index = NBYTES+2 (end of frame): `frame_cnt`+1 (wraps 255→0), then:
      - if pending is valid: move pending into active, clear pending, reset index and CHK, go to SEND;
      - else if `sample_tick` is high in the same cycle: latch it into active and go to SEND;
      - else go to IDLE.
- `sample_tick` while `busy`, outside the end-of-frame cycle:
  - pending empty: store into pending;
  - pending full: drop, `overrun_cnt`+1 saturating. Pending keeps the older capture.
- `sample_tick` in the end-of-frame cycle with pending full: pending is promoted and the tick's data becomes the new pending. Nothing is dropped.
- `tx_done` outside WAIT (IDLE or SEND) is ignored.
- Reset: every output and register goes to 0 (`tx_byte`=0) and the state goes to IDLE. A frame in progress is aborted and pending is discarded. A stale `tx_done` from the UART arriving after reset is ignored.

## Timing
- All outputs are registered. Combinational path from inputs to outputs is not allowed.
- `sample_tick` sampled at edge t (IDLE) → `tx_push`=1 and `tx_byte`=SYNC_BYTE in cycle t+1. `busy`=1 from cycle t+1.
- `tx_done` sampled at edge u → next `tx_push` in cycle u+1. Byte-to-byte overhead is exactly 1 cycle.
- `tx_push` is high for exactly 1 cycle per byte. There are never two pushes without an intervening `tx_done`.
- Last `tx_done` at edge u:
  - `frame_cnt` updates in cycle u+1;
  - `busy` falls in u+1 if no next frame;
  - otherwise SYNC of the next frame is pushed in u+1 and `busy` stays 1.
- `overrun_cnt` updates the cycle after the dropped tick.

## Test plan
- Idle start: reset, `sample_data`=64'hAA01_2345_AA01_2345, one tick; bench UART answers `tx_done` 20 cycles after each push → bytes A5 00 45 23 01 AA 45 23 01 AA 00. `frame_cnt`=1 and `busy`=0 after the last done. Push-to-tick latency is 1 cycle.
- Checksum and sequence: run 256 frames with `sample_data`=64'h0000_0000_0000_0001 → frame k sends SEQ=k mod 256 and CHK=(k mod 256)^01. `frame_cnt` wraps to 0.
- Pending and overrun: tick A; during byte 2, tick B then tick C → frame A, then frame B back-to-back (SYNC pushed the cycle after A's last done). C is never sent; `overrun_cnt`=1.
- Simultaneous end of frame: tick D in the same cycle as frame A's last `tx_done`, with pending B full → B is sent next, D after it, `overrun_cnt` unchanged. Repeat with pending empty → D is sent immediately.
- Saturation and spurious done: 300 ticks during one frame → `overrun_cnt`=255. Pulse `tx_done` while IDLE → no push, no state change.
- Reset mid-frame: assert `rst` during byte 5 → all outputs 0 asynchronously. A late `tx_done` is ignored. A new tick afterwards yields a fresh frame with SEQ=00.

Source files
------------

// File: rtl/tdc_frame_sequencer_if.sv
// Capture strobe, UART byte handshake and status counters of the TDC frame sequencer.
interface tdc_frame_sequencer_if #(parameter int DATASIZE = 64);
   logic                sample_tick;
   logic [DATASIZE-1:0] sample_data;
   logic                tx_push;
   logic [7:0]          tx_byte;
   logic                tx_done;
   logic                busy;
   logic [7:0]          frame_cnt;
   logic [7:0]          overrun_cnt;

   modport master (output sample_tick, sample_data, tx_done,
                   input  tx_push, tx_byte, busy, frame_cnt, overrun_cnt);
   modport slave  (input  sample_tick, sample_data, tx_done,
                   output tx_push, tx_byte, busy, frame_cnt, overrun_cnt);
endinterface

// File: rtl/tdc_frame_sequencer.sv
// Wraps each TDC capture as SYNC, SEQ, data bytes (LSB first), XOR checksum and paces
// them through the UART push/done handshake, with a one-deep pending capture buffer.
//   state  | meaning
//   S_IDLE | no frame, waiting for sample_tick
//   S_SEND | push the byte selected by idx, fold it into the checksum
//   S_WAIT | hold tx_byte until the UART reports tx_done
module tdc_frame_sequencer #(
   parameter int         DATASIZE  = 64,
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input logic                  clk10m,
   input logic                  rst,
   tdc_frame_sequencer_if.slave bus
);
   localparam int NBYTES = DATASIZE / 8;
   localparam int IDXW   = $clog2(NBYTES + 3);
   localparam logic [IDXW-1:0] SEQ_IDX  = IDXW'(1);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES + 2);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

   state_t              state, state_nx;
   logic [DATASIZE-1:0] active;
   logic [7:0]          seq;
   logic [DATASIZE-1:0] pend;
   logic                pend_valid;
   logic [IDXW-1:0]     idx;
   logic [7:0]          chk;
   logic [7:0]          frame_cnt_r;
   logic [7:0]          overrun_r;
   logic [7:0]          data_byte;
   logic [7:0]          cur_byte;
   logic                tick;
   logic                end_frame;

   assign tick      = bus.sample_tick;
   assign end_frame = (state == S_WAIT) && bus.tx_done && (idx == LAST_IDX);

   always_ff @(posedge clk10m or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: if (tick) state_nx = S_SEND;
         S_SEND: state_nx = S_WAIT;
         S_WAIT: begin
            if (bus.tx_done) begin
               if ((idx != LAST_IDX) || pend_valid || tick) state_nx = S_SEND;
               else                                         state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      data_byte = 8'h00;
      for (int i = 0; i < NBYTES; i++) begin
         if (idx == IDXW'(i + 2)) data_byte = active[8*i +: 8];
      end
   end

   always_comb begin
      cur_byte = data_byte;
      if (idx == '0)            cur_byte = SYNC_BYTE;
      else if (idx == SEQ_IDX)  cur_byte = seq;
      else if (idx == LAST_IDX) cur_byte = chk;
   end

   // Outputs decode registered state only, so no input reaches an output combinationally.
   always_comb begin
      bus.tx_push = (state == S_SEND);
      bus.busy    = (state != S_IDLE);
      bus.tx_byte = (state == S_IDLE) ? 8'h00 : cur_byte;
   end

   assign bus.frame_cnt   = frame_cnt_r;
   assign bus.overrun_cnt = overrun_r;

   always_ff @(posedge clk10m or posedge rst) begin
      if (rst) begin
         active      <= '0;
         seq         <= '0;
         pend        <= '0;
         pend_valid  <= 1'b0;
         idx         <= '0;
         chk         <= '0;
         frame_cnt_r <= '0;
         overrun_r   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (tick) begin
                  active <= bus.sample_data;
                  seq    <= frame_cnt_r;
                  idx    <= '0;
                  chk    <= '0;
               end
            end
            S_SEND: begin
               if ((idx != '0) && (idx != LAST_IDX)) chk <= chk ^ cur_byte;
            end
            S_WAIT: begin
               if (bus.tx_done) begin
                  if (idx != LAST_IDX) begin
                     idx <= idx + IDXW'(1);
                  end else begin
                     // Next frame (if any) carries the count after this one completes.
                     frame_cnt_r <= frame_cnt_r + 8'd1;
                     seq         <= frame_cnt_r + 8'd1;
                     idx         <= '0;
                     chk         <= '0;
                     if (pend_valid) begin
                        active     <= pend;
                        pend_valid <= tick;
                        if (tick) pend <= bus.sample_data;
                     end else if (tick) begin
                        active <= bus.sample_data;
                     end
                  end
               end
            end
            default: ;
         endcase

         if (tick && (state != S_IDLE) && !end_frame) begin
            if (!pend_valid) begin
               pend       <= bus.sample_data;
               pend_valid <= 1'b1;
            end else if (overrun_r != 8'hFF) begin
               overrun_r <= overrun_r + 8'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_tdc_frame_sequencer.sv
// Bench for tdc_frame_sequencer: frame-level reference model, UART responder and directed/random ticks.
module tb_tdc_frame_sequencer;
   localparam int         DATASIZE = 64;
   localparam int         NB       = DATASIZE / 8;
   localparam int         FLEN     = NB + 3;
   localparam logic [7:0] SYNC     = 8'hA5;

   logic clk10m = 1'b0;
   logic rst    = 1'b0;

   tdc_frame_sequencer_if #(.DATASIZE(DATASIZE)) bus ();

   tdc_frame_sequencer #(.DATASIZE(DATASIZE), .SYNC_BYTE(SYNC)) dut (
      .clk10m(clk10m),
      .rst   (rst),
      .bus   (bus)
   );

   always #50 clk10m = ~clk10m;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0]          exp_q[$];
   bit                  m_busy, m_pend_valid, m_push_exp;
   logic [DATASIZE-1:0] m_pend;
   int                  m_fcnt, m_ovr, m_left;

   int         done_timer = 0;
   int         uart_dly   = 20;
   bit         rand_dly   = 1'b0;
   bit         spur       = 1'b0;
   logic [7:0] last_byte  = 8'h00;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [DATASIZE-1:0] rnd_word();
      return {$urandom(), $urandom()};
   endfunction

   function automatic void model_reset();
      m_busy = 0; m_pend_valid = 0; m_push_exp = 0; m_pend = '0;
      m_fcnt = 0; m_ovr = 0; m_left = 0;
      exp_q.delete();
   endfunction

   // Frame contents from the byte-level definition: SYNC, SEQ, data LSB first, XOR of SEQ and data.
   function automatic void start_frame(input logic [DATASIZE-1:0] d);
      logic [7:0] c;
      logic [7:0] b;
      m_busy = 1; m_left = FLEN; m_push_exp = 1;
      c = 8'(m_fcnt);
      exp_q.push_back(SYNC);
      exp_q.push_back(c);
      for (int i = 0; i < NB; i++) begin
         b = d[8*i +: 8];
         exp_q.push_back(b);
         c = c ^ b;
      end
      exp_q.push_back(c);
   endfunction

   function automatic void model_edge(input bit tick, input logic [DATASIZE-1:0] d, input bit done);
      m_push_exp = 0;
      if (done && m_busy) begin
         m_left--;
         if (m_left == 0) begin
            m_fcnt = (m_fcnt + 1) % 256;
            if (m_pend_valid) begin
               start_frame(m_pend);
               m_pend_valid = tick;
               if (tick) m_pend = d;
            end else if (tick) begin
               start_frame(d);
            end else begin
               m_busy = 0;
            end
            return;
         end
         m_push_exp = 1;
      end
      if (tick) begin
         if (!m_busy) start_frame(d);
         else if (!m_pend_valid) begin
            m_pend_valid = 1; m_pend = d;
         end else if (m_ovr < 255) m_ovr++;
      end
   endfunction

   task automatic check_outputs();
      chk("tx_push", bus.tx_push, m_push_exp);
      if (bus.tx_push) begin
         chk("push_spacing", done_timer, 0);
         chk("byte_available", (exp_q.size() > 0), 1);
         if (exp_q.size() > 0) chk("tx_byte", bus.tx_byte, exp_q.pop_front());
         last_byte  = bus.tx_byte;
         done_timer = rand_dly ? int'($urandom_range(2, 5)) : uart_dly;
      end else if (m_busy && done_timer > 0) begin
         chk("tx_byte_hold", bus.tx_byte, last_byte);
      end
      chk("busy", bus.busy, m_busy);
      chk("frame_cnt", bus.frame_cnt, m_fcnt);
      chk("overrun_cnt", bus.overrun_cnt, m_ovr);
   endtask

   task automatic step(input bit tick, input logic [DATASIZE-1:0] d);
      bit done;
      done = (done_timer == 1);
      if (done_timer > 0) done_timer--;
      bus.sample_tick = tick;
      bus.sample_data = d;
      bus.tx_done     = done | spur;
      @(posedge clk10m);
      model_edge(tick, d, done | spur);
      #1;
      bus.sample_tick = 1'b0;
      bus.tx_done     = 1'b0;
      check_outputs();
   endtask

   task automatic wait_idle();
      int i = 0;
      while ((m_busy || done_timer != 0) && i < 20000) begin step(0, '0); i++; end
      chk("wait_idle_bound", (m_busy || done_timer != 0), 0);
   endtask

   task automatic wait_left(input int n);
      int i = 0;
      while (!(m_busy && m_left == n) && i < 2000) begin step(0, '0); i++; end
      chk("wait_left_bound", (m_busy && m_left == n), 1);
   endtask

   // Stops just before the step that delivers a frame's final tx_done.
   task automatic wait_last();
      int i = 0;
      while (!(m_busy && m_left == 1 && done_timer == 1) && i < 2000) begin step(0, '0); i++; end
      chk("wait_last_bound", (m_busy && m_left == 1 && done_timer == 1), 1);
   endtask

   task automatic async_reset();
      #10 rst = 1'b1;
      #1;
      chk("rst_busy", bus.busy, 0);
      chk("rst_push", bus.tx_push, 0);
      chk("rst_byte", bus.tx_byte, 0);
      chk("rst_frame_cnt", bus.frame_cnt, 0);
      chk("rst_overrun", bus.overrun_cnt, 0);
      model_reset();
      #10 rst = 1'b0;
   endtask

   initial begin
      bus.sample_tick = 1'b0;
      bus.sample_data = '0;
      bus.tx_done     = 1'b0;
      model_reset();
      #5 rst = 1'b1;
      #10;
      chk("init_busy", bus.busy, 0);
      chk("init_push", bus.tx_push, 0);
      chk("init_byte", bus.tx_byte, 0);
      chk("init_frame_cnt", bus.frame_cnt, 0);
      chk("init_overrun", bus.overrun_cnt, 0);
      #5 rst = 1'b0;

      // Single frame with known bytes: A5 00 45 23 01 AA 45 23 01 AA 00.
      uart_dly = 20;
      step(1, 64'hAA01_2345_AA01_2345);
      wait_idle();
      chk("first_frame_cnt", bus.frame_cnt, 1);

      // 256 frames of 0x..01: SEQ walks 0..255 and frame_cnt wraps.
      step(0, '0);
      async_reset();
      rand_dly = 1'b1;
      for (int k = 0; k < 256; k++) begin
         step(1, 64'h1);
         wait_idle();
      end
      chk("frame_cnt_wrap", bus.frame_cnt, 0);

      // Pending and overrun: A, then B and C during byte 2.
      rand_dly = 1'b0; uart_dly = 4;
      step(1, rnd_word());
      wait_left(FLEN - 2);
      step(1, rnd_word());
      step(1, rnd_word());
      wait_idle();
      chk("overrun_one", bus.overrun_cnt, 1);

      // Tick on the last tx_done with pending full, then with pending empty.
      step(1, rnd_word());
      wait_left(FLEN - 2);
      step(1, rnd_word());
      wait_last();
      step(1, rnd_word());
      wait_idle();
      chk("overrun_unchanged", bus.overrun_cnt, 1);
      step(1, rnd_word());
      wait_last();
      step(1, rnd_word());
      wait_idle();

      // 300 ticks inside one long frame saturate the overrun counter.
      uart_dly = 40;
      for (int k = 0; k < 300; k++) step(1, rnd_word());
      wait_idle();
      chk("overrun_sat", bus.overrun_cnt, 255);

      // Spurious tx_done while idle.
      spur = 1'b1;
      step(0, '0);
      spur = 1'b0;
      step(0, '0);
      step(0, '0);

      // Random ticks with random UART latency.
      rand_dly = 1'b1;
      for (int k = 0; k < 600; k++) step(($urandom_range(0, 11) == 0), rnd_word());
      wait_idle();

      // Reset during byte 5, stale tx_done afterwards, then a fresh frame from SEQ 00.
      rand_dly = 1'b0; uart_dly = 6;
      step(1, rnd_word());
      wait_left(FLEN - 5);
      step(0, '0);
      async_reset();
      for (int k = 0; k < 12; k++) step(0, '0);
      step(1, rnd_word());
      wait_idle();
      chk("post_reset_frame_cnt", bus.frame_cnt, 1);
      chk("queue_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
